// File: rtl/hub75_bcm_scan.sv
// hub75_bcm_scan -- HUB75 RGB LED-matrix scan driver with binary-coded modulation.
//
// Each row is sent once per colour bit-plane. For every plane the driver
// shifts COLS pixel pairs out of a synchronous framebuffer, latches them,
// then drives OE low for BASE_OE<<plane cycles. The result is CBITS bits
// per colour channel.
//
// Optional build macro HUB75_FB_SWAP_EN adds a buf_sel input and a
// framebuffer-select MSB on fb_addr. The selected buffer changes only at
// frame wrap or when the scan starts from IDLE.
//
// Ports:
//   clk, rst (async active-low), en   clock, reset, scan enable
//   fb_addr / fb_rdata                framebuffer read port {[buf,] row, col};
//                                     read latency is 1 cycle,
//                                     data is {R0,G0,B0,R1,G1,B1}
//   sclk, LAT, OE                     panel shift clock, latch, output enable (low)
//   row_addr                          panel row select
//   R0,G0,B0,R1,G1,B1                 colour data for the upper and lower half-panel
//   frame_done                        one-cycle pulse at frame wrap
module hub75_bcm_scan #(
  parameter int COLS      = 64,
  parameter int ADDR_BITS = 4,
  parameter int CBITS     = 4,
  parameter int CLK_DIV   = 2,
  parameter int BASE_OE   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
`ifdef HUB75_FB_SWAP_EN
  input  logic                               buf_sel,
  output logic [ADDR_BITS+$clog2(COLS):0]    fb_addr,
`else
  output logic [ADDR_BITS+$clog2(COLS)-1:0]  fb_addr,
`endif
  input  logic [6*CBITS-1:0]                 fb_rdata,
  output logic                               sclk,
  output logic                               LAT,
  output logic                               OE,
  output logic [ADDR_BITS-1:0]               row_addr,
  output logic                               R0,
  output logic                               G0,
  output logic                               B0,
  output logic                               R1,
  output logic                               G1,
  output logic                               B1,
  output logic                               frame_done
);
  localparam int CW  = $clog2(COLS);
  localparam int PW  = (CBITS > 1) ? $clog2(CBITS) : 1;
  localparam int PHW = $clog2(2*CLK_DIV);
  localparam int OEW = $clog2((BASE_OE << (CBITS-1)) + 1);

  localparam logic [PHW-1:0] PH_CAP  = PHW'(1);
  localparam logic [PHW-1:0] PH_SCLK = PHW'(CLK_DIV);
  localparam logic [PHW-1:0] PH_LAST = PHW'(2*CLK_DIV-1);
  localparam logic [CW-1:0]  COL_LAST = CW'(COLS-1);
  localparam logic [PW-1:0]  PL_LAST  = PW'(CBITS-1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  state_t               state, nxt;
  logic [ADDR_BITS-1:0] row;
  logic [PW-1:0]        plane;
  logic [CW-1:0]        col;
  logic [PHW-1:0]       phase;
  logic [OEW-1:0]       cnt;      // LATCH and DISPLAY cycle counter
  logic [OEW-1:0]       oe_last;
  logic                 shift_end, latch_end, disp_end, wrap;

  // The six colour fields of one pixel pair. R0 is index 5 (the MSBs).
  logic [5:0][CBITS-1:0] chan;
  assign chan = fb_rdata;

`ifdef HUB75_FB_SWAP_EN
  logic buf_q;
  assign fb_addr = {buf_q, row, col};
`else
  assign fb_addr = {row, col};
`endif

  assign oe_last = (OEW'(BASE_OE) << plane) - OEW'(1);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nxt;

  // Next-state logic and output decode. The panel control lines depend only
  // on the state register, so an asynchronous reset blanks OE immediately.
  always_comb begin
    nxt       = state;
    sclk      = 1'b0;
    LAT       = 1'b0;
    OE        = 1'b1;
    shift_end = (state == SHIFT) && (col == COL_LAST) && (phase == PH_LAST);
    latch_end = (state == LATCH) && (cnt == OEW'(1));
    disp_end  = (state == DISPLAY) && (cnt == oe_last);
    wrap      = (row == {ADDR_BITS{1'b1}}) && (plane == PL_LAST);
    case (state)
      IDLE:    if (en) nxt = SHIFT;
      SHIFT: begin
        sclk = (phase >= PH_SCLK);
        if (shift_end) nxt = LATCH;
      end
      LATCH: begin
        LAT = 1'b1;
        if (latch_end) nxt = DISPLAY;
      end
      DISPLAY: begin
        OE = 1'b0;
        if (disp_end) nxt = en ? SHIFT : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row        <= '0;
      plane      <= '0;
      col        <= '0;
      phase      <= '0;
      cnt        <= '0;
      row_addr   <= '0;
      {R0, G0, B0, R1, G1, B1} <= '0;
      frame_done <= 1'b0;
`ifdef HUB75_FB_SWAP_EN
      buf_q      <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          row   <= '0;
          plane <= '0;
          col   <= '0;
          phase <= '0;
`ifdef HUB75_FB_SWAP_EN
          if (en) buf_q <= buf_sel;
`endif
        end
        SHIFT: begin
          cnt <= '0;
          // Read data for the column addressed in phase 0 is valid in phase 1.
          if (phase == PH_CAP)
            {R0, G0, B0, R1, G1, B1} <= {chan[5][plane], chan[4][plane], chan[3][plane],
                                         chan[2][plane], chan[1][plane], chan[0][plane]};
          if (phase == PH_LAST) begin
            phase <= '0;
            col   <= col + CW'(1);   // COLS is a power of 2, so col wraps to 0
          end else begin
            phase <= phase + PHW'(1);
          end
          // Change the row select while the panel is blanked.
          if (shift_end) row_addr <= row;
        end
        LATCH: cnt <= latch_end ? '0 : cnt + OEW'(1);
        DISPLAY: begin
          cnt <= cnt + OEW'(1);
          if (disp_end) begin
            if (plane == PL_LAST) begin
              plane <= '0;
              row   <= row + ADDR_BITS'(1);
            end else begin
              plane <= plane + PW'(1);
            end
            if (wrap) begin
              frame_done <= 1'b1;
`ifdef HUB75_FB_SWAP_EN
              buf_q      <= buf_sel;
`endif
            end
            // Dropping en always restarts the next scan at row 0, plane 0.
            if (!en) begin
              row   <= '0;
              plane <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Scoreboard bench for hub75_bcm_scan. The stimulus pushes the expected panel
// events into a queue in order: shifted columns, latches, OE windows and
// frame_done. The expected events come from the framebuffer contents and the
// BCM timing rules. A monitor pops and compares each event as the DUT
// produces it.
module tb_hub75_bcm_scan;
  localparam int COLS = 4, ADDR_BITS = 2, CBITS = 2, CLK_DIV = 2, BASE_OE = 4;
  localparam int ROWS = 1 << ADDR_BITS;
  localparam int DW = 6*CBITS;
`ifdef HUB75_FB_SWAP_EN
  localparam int AW = ADDR_BITS + $clog2(COLS) + 1;
`else
  localparam int AW = ADDR_BITS + $clog2(COLS);
`endif
  localparam int K_NONE = 0, K_COL = 1, K_LAT = 2, K_DISP = 3, K_FD = 4;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_rdata;
  logic sclk, LAT, OE, R0, G0, B0, R1, G1, B1, frame_done;
  logic [ADDR_BITS-1:0] row_addr;
`ifdef HUB75_FB_SWAP_EN
  logic buf_sel = 1'b0;
`endif

  hub75_bcm_scan #(.COLS(COLS), .ADDR_BITS(ADDR_BITS), .CBITS(CBITS),
                   .CLK_DIV(CLK_DIV), .BASE_OE(BASE_OE)) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef HUB75_FB_SWAP_EN
    .buf_sel(buf_sel),
`endif
    .fb_addr(fb_addr), .fb_rdata(fb_rdata), .sclk(sclk), .LAT(LAT), .OE(OE),
    .row_addr(row_addr), .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .frame_done(frame_done));

  always #5 clk = ~clk;

  // Synchronous framebuffer model with a 1-cycle read latency.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) fb_rdata <= mem[fb_addr];

  typedef struct {
    int       kind;
    logic [5:0] rgb;
    int       addr;
    int       row;
    int       len;
    int       gap;
    int       per;
  } item_t;
  item_t q[$];

  int n_chk = 0, n_fail = 0;
  logic mon_on = 1'b0;

  task automatic check(string name, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected events for one (row, plane). Bit 'p' of each colour channel is
  // shifted out for every column. Latch and OE lengths follow the BCM rules.
  task automatic push_plane(int r, int p, bit with_disp);
    item_t it;
    for (int c = 0; c < COLS; c++) begin
      int a;
      a = r*COLS + c;
      it = '{default: 0};
      it.kind = K_COL;
      it.addr = a;
      it.gap  = (c == 0) ? -1 : 2*CLK_DIV;
      for (int k = 0; k < 6; k++) begin
        int chv;
        chv = int'((mem[a] >> ((5-k)*CBITS))) & ((1 << CBITS) - 1);
        it.rgb[5-k] = ((chv >> p) & 1) != 0;
      end
      q.push_back(it);
    end
    it = '{default: 0};
    it.kind = K_LAT; it.row = r; it.len = 2;
    q.push_back(it);
    if (with_disp) begin
      it = '{default: 0};
      it.kind = K_DISP;
      it.len  = BASE_OE << p;
      // from the first sclk rise (phase CLK_DIV) to the end of DISPLAY
      it.per  = COLS*2*CLK_DIV + 2 + (BASE_OE << p) - CLK_DIV;
      q.push_back(it);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < CBITS; p++) push_plane(r, p, 1'b1);
  endtask

  task automatic push_fd(int period);
    item_t it;
    it = '{default: 0};
    it.kind = K_FD; it.len = period;
    q.push_back(it);
  endtask

  task automatic pop(output item_t it);
    if (q.size() == 0) begin
      it = '{default: 0};
      it.kind = K_NONE;
    end else begin
      it = q.pop_front();
    end
  endtask

  task automatic wait_q(int target, int bound, string name);
    int t;
    t = 0;
    while (q.size() != target && t < bound) begin
      @(negedge clk); #1;
      t++;
    end
    check(name, q.size(), target);
  endtask

  // Monitor: turns output waveforms into events and checks them against the queue.
  int cyc = 0, last_rise = 0, plane_start = 0, last_fd = 0, lat_len = 0, oe_len = 0;
  logic sclk_q = 1'b0, lat_q = 1'b0, oe_q = 1'b1, fd_q = 1'b0, lat_oe = 1'b1;
  logic [ADDR_BITS-1:0] lat_row = '0;
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (!mon_on) begin
        sclk_q = 1'b0; lat_q = 1'b0; oe_q = 1'b1; fd_q = 1'b0;
        continue;
      end
      cyc++;
      if (sclk) check("sclk_only_when_blanked", {LAT, OE}, 2'b01);
      if (sclk && !sclk_q) begin
        pop(it);
        check("col_kind", it.kind, K_COL);
        check("col_rgb", {R0, G0, B0, R1, G1, B1}, it.rgb);
        check("col_fb_addr", fb_addr, it.addr);
        if (it.gap >= 0) check("col_spacing", cyc - last_rise, it.gap);
        else plane_start = cyc;
        last_rise = cyc;
      end
      if (LAT) begin
        if (!lat_q) begin lat_len = 0; lat_row = row_addr; lat_oe = 1'b1; end
        lat_len++;
        if (!OE) lat_oe = 1'b0;
      end else if (lat_q) begin
        pop(it);
        check("lat_kind", it.kind, K_LAT);
        check("lat_row_addr", lat_row, it.row);
        check("lat_len", lat_len, it.len);
        check("lat_oe_high", lat_oe, 1);
      end
      if (!OE) begin
        if (oe_q) oe_len = 0;
        oe_len++;
      end else if (!oe_q) begin
        pop(it);
        check("oe_kind", it.kind, K_DISP);
        check("oe_low_len", oe_len, it.len);
        check("plane_period", cyc - plane_start, it.per);
      end
      if (fd_q) check("frame_done_width", frame_done, 0);
      else if (frame_done) begin
        pop(it);
        check("fd_kind", it.kind, K_FD);
        if (it.len > 0) check("fd_period", cyc - last_fd, it.len);
        last_fd = cyc;
      end
      sclk_q = sclk; lat_q = LAT; oe_q = OE; fd_q = frame_done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i] = DW'($urandom);
      mem[i][DW-1 -: CBITS] = CBITS'(2);   // R0 field = 2'b10
    end
    rst = 1'b0; en = 1'b1;
    #2;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs",
            {OE, sclk, LAT, row_addr, R0, G0, B0, R1, G1, B1, frame_done, fb_addr},
            64'd1 << (11 + AW));
    end

    // Two full frames, then drop en during the SHIFT of row 1, plane 0.
    push_frame(); push_fd(0);
    push_frame(); push_fd(192);
    push_plane(0, 0, 1'b1); push_plane(0, 1, 1'b1); push_plane(1, 0, 1'b1);
    @(negedge clk); #1;
    rst = 1'b1; mon_on = 1'b1;
    wait_q(5, 700, "reach_row1_shift");
    en = 1'b0;
    wait_q(0, 200, "drain_after_en_drop");
    repeat (5) begin
      @(negedge clk);
      check("idle_outputs", {OE, sclk, LAT}, 3'b100);
      check("idle_fb_addr", fb_addr, 0);
    end

    // Fresh random image. Restart from IDLE, then reset asynchronously
    // during the DISPLAY of row 1, plane 0.
    @(negedge clk); #1;
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
    push_frame(); push_fd(0);
    push_plane(0, 0, 1'b1); push_plane(0, 1, 1'b1); push_plane(1, 0, 1'b0);
    en = 1'b1;
    wait_q(0, 400, "reach_row1_display");
    @(posedge clk); #2;
    mon_on = 1'b0;
    check("mid_display_oe", OE, 0);
    check("mid_display_row", row_addr, 1);
    rst = 1'b0;
    #1;
    check("async_reset_outputs",
          {OE, sclk, LAT, row_addr, R0, G0, B0, R1, G1, B1, frame_done},
          64'd1 << 11);
    @(negedge clk);
    check("async_reset_hold", {OE, LAT, row_addr}, 4'b1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_scan.md
Name: hub75_bcm_scan

Overview:
- Parametrised HUB75 RGB LED-matrix scan driver.
- Reads pixels from a synchronous framebuffer read port and shifts colour bit-planes into the panel with a generated shift clock.
- Latches each plane and drives OE for binary-coded-modulation (BCM) on-times, giving CBITS bits per colour channel.
- Sits between the framebuffer RAM and the panel connector. Generalises the fixed 4-address-line, 1-bit-colour driver.

Parameters:
- COLS, 64: panel columns per row (power of 2, >=2).
- ADDR_BITS, 4: row address lines. Rows per half-panel = 2**ADDR_BITS.
- CBITS, 4: bits per colour channel (1..8).
- CLK_DIV, 2: system clocks per sclk half-period (>=2).
- BASE_OE, 8: OE-low cycles for bit-plane 0 (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- fb_addr  out  ADDR_BITS+log2(COLS)  framebuffer read address {row, col}.
- fb_rdata  in  6*CBITS  pixel pair, 1-cycle read latency, packed {R0,G0,B0,R1,G1,B1}, each CBITS wide (R0 in MSBs).
- sclk  out  1  panel shift clock; data is sampled by the panel on the rising edge.
- LAT  out  1  panel latch, active-high.
- OE  out  1  panel output enable, active-low.
- row_addr  out  ADDR_BITS  panel row select (A=bit0, B=bit1, ...).
- R0,G0,B0,R1,G1,B1  out  1 each  upper-half and lower-half colour bits.
- frame_done  out  1  one-cycle pulse at frame wrap.

Behaviour:
- Reset (rst=0, asynchronous): OE=1, all other outputs 0, state IDLE, row=0, plane=0. Outputs hold these values while rst is low.
- States: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE:
  - OE=1, sclk=0, LAT=0.
  - Moves to SHIFT on the first cycle en=1, always starting at row 0, plane 0.
  - Minimum one cycle in IDLE.
- SHIFT:
  - OE=1. Each column occupies 2*CLK_DIV cycles, with phase p running 0..2*CLK_DIV-1.
  - p=0: fb_addr={row,col}.
  - p=1: colour outputs register bit[plane] of each channel from fb_rdata.
  - sclk=1 while p>=CLK_DIV, else 0.
  - Total SHIFT length is COLS*2*CLK_DIV cycles. sclk is 0 on exit.
- LATCH:
  - 2 cycles, LAT=1, OE=1.
  - row_addr updates to the current row on the first LATCH cycle, so the row changes only while blanked.
- DISPLAY:
  - OE=0 for BASE_OE<<plane cycles, then the block advances.
  - If plane<CBITS-1: plane+1, same row.
  - Otherwise: plane=0, row+1.
  - After row 2**ADDR_BITS-1 / plane CBITS-1: row wraps to 0, and frame_done=1 for exactly one cycle (the first cycle of the next SHIFT).
- Next state after DISPLAY: SHIFT if en=1, else IDLE.
- en=0 is honoured only at DISPLAY exit; the current plane always completes.
- Plane period = COLS*2*CLK_DIV + 2 + (BASE_OE<<plane) cycles.
- Colour outputs hold their last value through LATCH and DISPLAY.
- Counter widths: column log2(COLS), plane ceil(log2(CBITS)) min 1, OE counter wide enough for BASE_OE<<(CBITS-1).
- Reset mid-operation blanks immediately (OE=1) with no completion of the current plane.

Optional Feature:
- Macro: HUB75_FB_SWAP_EN.
- With the macro defined:
  - Adds input buf_sel (1 bit).
  - fb_addr gains one MSB, {buf, row, col}.
  - buf_sel is sampled only at frame wrap (the frame_done cycle) and on IDLE->SHIFT, so the displayed buffer never changes mid-frame.
  - Internal buf resets to 0.
- Without the macro: no buf_sel port, and fb_addr is ADDR_BITS+log2(COLS) wide.

Test Plan (COLS=4, ADDR_BITS=2, CBITS=2, CLK_DIV=2, BASE_OE=4):
- Reset: hold rst=0 for 3 cycles with en=1 -> OE=1; sclk, LAT, row_addr, RGB, frame_done = 0 throughout.
- Shift:
  - Stimulus: en=1, fb model returns R0 field=2'b10 for all addresses.
  - Required: fb_addr steps 0,1,2,3, one new column every 4 cycles; 4 sclk rising edges per SHIFT (16 cycles).
  - R0=0 at each rising edge in plane 0, R0=1 in plane 1.
- Latch/BCM: after SHIFT -> LAT=1 for 2 cycles with OE=1 and row_addr updated; then OE=0 for 4 cycles (plane 0) and 8 cycles (plane 1).
- Frame wrap: continuous en=1 -> row_addr sequence 0,1,2,3,0. frame_done pulses once per 4*(2*(16+2)+4+8)=192 cycles.
- Enable drop: deassert en mid-SHIFT of row 1, plane 0 -> that plane finishes its DISPLAY (4 cycles OE=0), then IDLE with OE=1. Re-assert en -> restarts at row 0, plane 0 with fb_addr=0.
- Async reset: assert rst=0 mid-DISPLAY, between clock edges -> OE=1 and row_addr=0 immediately, without waiting for a clock edge. With HUB75_FB_SWAP_EN: toggle buf_sel mid-frame -> fb_addr MSB changes only at the next frame_done.
